ram_burst_reader: RTL and testbench

- Read-side initiator for one port of the team's dual-port synchronous-read RAMs, such as the initialized bcrypt constant RAMs.
- On a start command it reads a contiguous burst of words from the RAM port and presents them in address order on a valid/ready output stream.
- It absorbs the RAM's 1-cycle read latency and downstream backpressure with an internal 4-entry skid FIFO, so it sustains one word per cycle.
- Typical use: copying P-array/S-box initial constants into working state or to the host.

---
 rtl/ram_burst_reader_pkg.sv | 15 +
 rtl/ram_burst_reader_if.sv | 28 ++
 rtl/ram_burst_fifo.sv | 52 +++++
 rtl/ram_burst_reader.sv | 127 ++++++++++++
 tb/tb_ram_burst_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: controller states and skid FIFO sizing.
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/ram_burst_reader_if.sv
// Bus bundle between the burst reader, one RAM read port and the downstream stream.
interface ram_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    // A beat transfers on a cycle with m_valid=1 and m_ready=1; once raised, m_valid and
    // m_data hold unchanged until that transfer, and m_valid never depends on m_ready.
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output ram_en, ram_we, ram_addr, ram_din, m_data, m_valid,
        input  ram_dout, m_ready
    );

    modport slave (
        input  ram_en, ram_we, ram_addr, ram_din, m_data, m_valid,
        output ram_dout, m_ready
    );

endinterface

// File: rtl/ram_burst_fifo.sv
// Four-entry synchronous skid FIFO; the head is presented combinationally from storage.
module ram_burst_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  not_empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    assign head_data = not_empty ? storage[rd_ptr] : '0;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: walks a contiguous (wrapping) address range on one RAM port and
// streams the words out in address order through a skid FIFO that hides the read latency.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output state_t                state_dbg,
    output logic [FIFO_CNT_W-1:0] fifo_count,
    ram_burst_reader_if.master    bus
);

    state_t                state;
    logic                  ram_en_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  rd_pending;
    logic [ADDR_WIDTH:0]   issue_left;

    logic [1:0]            inflight;
    logic [FIFO_CNT_W-1:0] occupancy;
    logic                  can_issue;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  pop;
    logic                  drain_done;

    // Every issued read owns a FIFO slot from issue until it is popped; pops in the
    // current cycle are deliberately not credited so the check stays registered-only.
    assign inflight   = {1'b0, ram_en_q} + {1'b0, rd_pending};
    assign occupancy  = fifo_count + FIFO_CNT_W'(inflight);
    assign can_issue  = (occupancy < FIFO_CNT_W'(FIFO_DEPTH));
    assign pop        = fifo_valid && bus.m_ready;
    // Leave DRAIN while the final beat transfers so done lands the very next cycle.
    assign drain_done = (inflight == 2'd0) &&
                        ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            rd_pending <= 1'b0;
            issue_left <= '0;
        end else begin
            rd_pending <= ram_en_q;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ram_en_q <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= base_addr;
                            issue_left <= length - (ADDR_WIDTH+1)'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_left == '0) begin
                        ram_en_q <= 1'b0;
                        state    <= ST_DRAIN;
                    end else if (can_issue) begin
                        ram_en_q   <= 1'b1;
                        ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
                        issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
                    end else begin
                        ram_en_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    ram_en_q <= 1'b0;
                    if (drain_done) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ram_en_q <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    ram_en_q <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    ram_burst_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data (bus.ram_dout),
        .pop       (pop),
        .head_data (fifo_head),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.ram_en   = ram_en_q;
    assign bus.ram_we   = 1'b0;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = '0;
    assign bus.m_data   = fifo_head;
    assign bus.m_valid  = fifo_valid;
    assign state_dbg    = state;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: cycle table for fixed bursts, hand sequences for reset and
// command corner cases, and random bursts scored against a per-word address model.
module tb_ram_burst_reader;
    import ram_burst_reader_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    state_t        state_dbg;
    logic [2:0]    fifo_count;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    ram_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg),
        .fifo_count (fifo_count),
        .bus        (bus)
    );

    // clock / RAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] preload_word(input logic [AW-1:0] a);
        return 32'(a) + 32'h100;
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            case (c % 4)
                0: return 1'b1;
                1: return 1'b0;
                2: return 1'b0;
                default: return 1'b1;
            endcase
        end
        return ($urandom_range(0, 99) < 70);
    endfunction

    // cycle table
    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic          ready;
        logic          busy;
        logic          done;
        logic          en;
        logic          addr_care;
        logic [AW-1:0] addr;
        logic          valid;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vec_q [$];

    task automatic add_row(input logic st, input logic [AW-1:0] b, input logic [AW:0] l,
                           input logic rdy, input logic bz, input logic dn, input logic en,
                           input logic ac, input logic [AW-1:0] a, input logic v,
                           input logic [DW-1:0] d);
        vec_t r;
        r.start = st; r.base = b; r.len = l; r.ready = rdy;
        r.busy = bz; r.done = dn; r.en = en; r.addr_care = ac; r.addr = a;
        r.valid = v; r.data = d;
        vec_q.push_back(r);
    endtask

    task automatic add_burst4(input logic [AW-1:0] b);
        add_row(1'b1, b,  10'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, b, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, b + AW'(1), 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, b + AW'(2), 1'b1, preload_word(b));
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, b + AW'(3), 1'b1, preload_word(b + AW'(1)));
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, preload_word(b + AW'(2)));
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, preload_word(b + AW'(3)));
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic run_table();
        foreach (vec_q[i]) begin
            @(posedge clk); #1;
            start = vec_q[i].start;
            base_addr = vec_q[i].base;
            length = vec_q[i].len;
            bus.m_ready = vec_q[i].ready;
            #1;
            check($sformatf("vec%0d_busy", i), busy, vec_q[i].busy);
            check($sformatf("vec%0d_done", i), done, vec_q[i].done);
            check($sformatf("vec%0d_ram_en", i), bus.ram_en, vec_q[i].en);
            check($sformatf("vec%0d_m_valid", i), bus.m_valid, vec_q[i].valid);
            if (vec_q[i].addr_care) check($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vec_q[i].addr);
            if (vec_q[i].valid) check($sformatf("vec%0d_m_data", i), bus.m_data, vec_q[i].data);
        end
        start = 1'b0;
    endtask

    // driver + scoreboard for one burst; repulse names a cycle that re-pulses start
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] len,
                             input int mode, input int repulse);
        int hs = 0, first_hs = -1, last_hs = -1, done_cyc = -1, budget;
        logic stall = 1'b0;
        logic [DW-1:0] held = '0;
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
        budget = 4 * int'(len) + 40;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = len;
        bus.m_ready = ready_for(mode, 0);
        #1;
        check("idle_before_start", busy, 1'b0);
        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            start = (c == repulse);
            if (c == repulse) begin base_addr = AW'(100); length = 10'd5; end
            bus.m_ready = ready_for(mode, c);
            #1;
            if (stall) begin
                check("hold_valid", bus.m_valid, 1'b1);
                check("hold_data", bus.m_data, held);
            end
            check("fifo_overflow", fifo_count <= 3'd4, 1'b1);
            check("ram_we", bus.ram_we, 1'b0);
            check("ram_din", bus.ram_din, '0);
            check("busy_during", busy, 1'b1);
            if (len == '0) check("no_issue_len0", bus.ram_en, 1'b0);
            if (bus.m_valid && bus.m_ready) begin
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("beat_data", bus.m_data, exp_q.pop_front());
                hs++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            stall = bus.m_valid && !bus.m_ready;
            held = bus.m_data;
            if (done) done_cyc = c;
        end
        start = 1'b0;
        check("done_seen", done_cyc >= 0, 1'b1);
        check("beat_count", hs, 64'(len));
        check("leftover_words", exp_q.size(), 0);
        if (len == '0) check("done_cycle_len0", done_cyc, 1);
        else check("done_after_last_beat", done_cyc, last_hs + 1);
        if (mode == 0 && len != '0) begin
            check("first_valid_cycle", first_hs, 3);
            check("no_bubbles", last_hs - first_hs, int'(len) - 1);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        #1;
        check("post_busy", busy, 1'b0);
        check("post_done", done, 1'b0);
        check("post_valid", bus.m_valid, 1'b0);
        check("post_ram_en", bus.ram_en, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ram_en"}, bus.ram_en, 1'b0);
        check({tag, "_ram_addr"}, bus.ram_addr, '0);
        check({tag, "_m_valid"}, bus.m_valid, 1'b0);
        check({tag, "_m_data"}, bus.m_data, '0);
        check({tag, "_fifo_count"}, fifo_count, '0);
        check({tag, "_state"}, state_dbg, ST_IDLE);
    endtask

    task automatic reset_mid_burst();
        int hs = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(200); length = 10'd10; bus.m_ready = 1'b1;
        for (int c = 1; c <= 30 && hs < 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (bus.m_valid && bus.m_ready) hs++;
        end
        check("rst_three_beats_seen", hs, 3);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check("rst_no_done", done, 1'b0);
            check("rst_no_valid", bus.m_valid, 1'b0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_burst(AW'(300), 10'd3, 0, -1);
    endtask

    initial begin
        bus.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = preload_word(AW'(i));
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        add_burst4(AW'(5));
        add_burst4(AW'(510));
        add_row(1'b1, AW'(7), '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        add_row(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        run_table();

        run_burst(AW'(40), 10'd16, 1, -1);
        run_burst(AW'(20), 10'd8, 0, 3);
        run_burst(AW'(5), 10'd4, 0, 7);
        reset_mid_burst();
        run_burst(AW'(300), 10'd512, 0, -1);

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int n = 0; n < 24; n++) begin
            int r;
            logic [AW:0] len;
            r = $urandom_range(0, 9);
            if (r == 0) len = '0;
            else if (r == 1) len = 10'd512;
            else len = (AW+1)'($urandom_range(1, 40));
            run_burst(AW'($urandom_range(0, DEPTH - 1)), len, 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
